// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, defaults and window helpers for the Sobel stage
package sobel_pkg;

    localparam int PIXEL_W              = 8;
    localparam int WINDOW_W             = 72;
    localparam int PSUM_W               = 10;
    localparam int GRAD_W               = 11;
    localparam int MAG_W                = 11;
    localparam int FRAME_CNT_W          = 20;
    localparam int DEFAULT_FRAME_PIXELS = 919040;

    typedef struct packed {
        logic [PSUM_W-1:0] gx_pos;
        logic [PSUM_W-1:0] gx_neg;
        logic [PSUM_W-1:0] gy_pos;
        logic [PSUM_W-1:0] gy_neg;
    } psum_t;

    function automatic logic [PIXEL_W-1:0] pix(input logic [WINDOW_W-1:0] w, input int r, input int c);
        return w[24*r + 8*c +: PIXEL_W];
    endfunction

    // a + 2b + c, the 1-2-1 weighted sum of one kernel column or row
    function automatic logic [PSUM_W-1:0] psum3(input logic [PIXEL_W-1:0] a,
                                                input logic [PIXEL_W-1:0] b,
                                                input logic [PIXEL_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

endpackage

// File: rtl/sobel_grad.sv
// rtl/sobel_grad.sv - S1 partial sums and S2 absolute gradients, shared stall enable
module sobel_grad
    import sobel_pkg::*;
(
    input  logic                Clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid_in,
    input  logic [WINDOW_W-1:0] window,
    output logic                valid_out,
    output logic [PSUM_W-1:0]   abs_gx,
    output logic [PSUM_W-1:0]   abs_gy
);

    psum_t ps_d;
    psum_t ps_q;
    logic  s1_valid;

    always_comb begin
        ps_d.gx_pos = psum3(pix(window, 0, 2), pix(window, 1, 2), pix(window, 2, 2));
        ps_d.gx_neg = psum3(pix(window, 0, 0), pix(window, 1, 0), pix(window, 2, 0));
        ps_d.gy_pos = psum3(pix(window, 2, 0), pix(window, 2, 1), pix(window, 2, 2));
        ps_d.gy_neg = psum3(pix(window, 0, 0), pix(window, 0, 1), pix(window, 0, 2));
    end

    // |a - b| taken directly as an ordered difference, equivalent to abs of the signed gradient
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            ps_q      <= '0;
            valid_out <= 1'b0;
            abs_gx    <= '0;
            abs_gy    <= '0;
        end else if (en) begin
            s1_valid  <= valid_in;
            ps_q      <= ps_d;
            valid_out <= s1_valid;
            abs_gx    <= (ps_q.gx_pos >= ps_q.gx_neg) ? ps_q.gx_pos - ps_q.gx_neg
                                                      : ps_q.gx_neg - ps_q.gx_pos;
            abs_gy    <= (ps_q.gy_pos >= ps_q.gy_neg) ? ps_q.gy_pos - ps_q.gy_neg
                                                      : ps_q.gy_neg - ps_q.gy_pos;
        end
    end

endmodule

// File: rtl/sobel_conv.sv
// rtl/sobel_conv.sv - 3-stage Sobel magnitude with output register, frame counter and backpressure
module sobel_conv
    import sobel_pkg::*;
#(
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int THRESHOLD    = 0
) (
    input  logic                Clk,
    input  logic                rst,
    input  logic                pixel_data_valid_in,
    input  logic [WINDOW_W-1:0] pixel_data_in,
    output logic                pixel_ready_out,
    output logic                convolved_data_valid_out,
    output logic [PIXEL_W-1:0]  convolved_data_out,
    output logic                convolved_last_out,
    input  logic                dma_ready_in
);

    localparam logic [31:0]            THR      = THRESHOLD;
    localparam logic [FRAME_CNT_W-1:0] LAST_IDX = FRAME_CNT_W'(FRAME_PIXELS - 1);

    logic                   en;
    logic                   s2_valid;
    logic [PSUM_W-1:0]      abs_gx;
    logic [PSUM_W-1:0]      abs_gy;
    logic [MAG_W-1:0]       mag;
    logic [PIXEL_W-1:0]     pix_d;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // An empty output register always lets the pipeline advance, so fill bubbles collapse
    assign en              = !convolved_data_valid_out || dma_ready_in;
    assign pixel_ready_out = en;

    sobel_grad u_grad (
        .Clk       (Clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (pixel_data_valid_in),
        .window    (pixel_data_in),
        .valid_out (s2_valid),
        .abs_gx    (abs_gx),
        .abs_gy    (abs_gy)
    );

    always_comb begin
        mag = {1'b0, abs_gx} + {1'b0, abs_gy};
        if (THRESHOLD != 0)
            pix_d = (32'(mag) >= THR) ? 8'hFF : 8'h00;
        else
            pix_d = (|mag[MAG_W-1:PIXEL_W]) ? 8'hFF : mag[PIXEL_W-1:0];
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            convolved_data_valid_out <= 1'b0;
            convolved_data_out       <= '0;
        end else if (en) begin
            convolved_data_valid_out <= s2_valid;
            convolved_data_out       <= pix_d;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (convolved_data_valid_out && dma_ready_in)
            frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + 1'b1;
    end

    assign convolved_last_out = convolved_data_valid_out && (frame_cnt == LAST_IDX);

endmodule

// File: tb/tb_sobel_conv.sv
// tb/tb_sobel_conv.sv - directed table and sequence bench for sobel_conv
module tb_sobel_conv;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_data_valid_in = 1'b0;
    logic [71:0] pixel_data_in = '0;
    logic        dma_ready_in = 1'b1;

    logic        ready, conv_valid, conv_last;
    logic [7:0]  conv_data;
    logic        r100, v100, l100, r200, v200, l200;
    logic [7:0]  d100, d200;

    int total = 0;
    int passed = 0;

    always #5 Clk = ~Clk;

    sobel_conv #(.FRAME_PIXELS(8), .THRESHOLD(0)) dut (
        .Clk(Clk), .rst(rst), .pixel_data_valid_in(pixel_data_valid_in), .pixel_data_in(pixel_data_in),
        .pixel_ready_out(ready), .convolved_data_valid_out(conv_valid), .convolved_data_out(conv_data),
        .convolved_last_out(conv_last), .dma_ready_in(dma_ready_in));

    sobel_conv #(.FRAME_PIXELS(8), .THRESHOLD(100)) dut_t100 (
        .Clk(Clk), .rst(rst), .pixel_data_valid_in(pixel_data_valid_in), .pixel_data_in(pixel_data_in),
        .pixel_ready_out(r100), .convolved_data_valid_out(v100), .convolved_data_out(d100),
        .convolved_last_out(l100), .dma_ready_in(dma_ready_in));

    sobel_conv #(.FRAME_PIXELS(8), .THRESHOLD(200)) dut_t200 (
        .Clk(Clk), .rst(rst), .pixel_data_valid_in(pixel_data_valid_in), .pixel_data_in(pixel_data_in),
        .pixel_ready_out(r200), .convolved_data_valid_out(v200), .convolved_data_out(d200),
        .convolved_last_out(l200), .dma_ready_in(dma_ready_in));

    typedef struct {
        logic [71:0] w;
        logic [7:0]  e0;
        logic [7:0]  e100;
        logic [7:0]  e200;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [71:0] px1(input int r, input int c, input int v);
        logic [71:0] w;
        w = '0;
        w[24*r + 8*c +: 8] = 8'(v);
        return w;
    endfunction

    function automatic logic [71:0] rowfill(input int r, input int v);
        logic [71:0] w;
        w = '0;
        for (int c = 0; c < 3; c++) w |= px1(r, c, v);
        return w;
    endfunction

    function automatic logic [71:0] colfill(input int c, input int v);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) w |= px1(r, c, v);
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pixel_data_valid_in = 1'b0;
        dma_ready_in = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Streams n windows (p12 = k+1, so out = 2(k+1)); last expected on every 8th output
    task automatic run_stream(input int n, input string tag);
        int  sent;
        int  got;
        logic acc;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
            dma_ready_in = 1'b1;
            pixel_data_valid_in = (sent < n);
            pixel_data_in = (sent < n) ? px1(1, 2, sent + 1) : '0;
            #1;
            acc = pixel_data_valid_in && ready;
            if (conv_valid) begin
                if (got == 0) chk({tag, "_latency"}, cyc, 3);
                chk({tag, "_data"}, conv_data, 2 * (got + 1));
                chk({tag, "_last"}, conv_last, (got % 8) == 7);
                got++;
            end
            @(posedge Clk);
            #1;
            if (acc) sent++;
        end
        pixel_data_valid_in = 1'b0;
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        int   sent, got;
        logic acc, prev_stall;
        logic [7:0] prev_data;

        vecs[0]  = '{{9{8'd100}},                      8'd0,   8'd0,   8'd0};
        vecs[1]  = '{colfill(1, 255) | colfill(2, 255), 8'd255, 8'd255, 8'd255};
        vecs[2]  = '{colfill(2, 10),                    8'd40,  8'd0,   8'd0};
        vecs[3]  = '{rowfill(2, 30),                    8'd120, 8'd255, 8'd0};
        vecs[4]  = '{px1(0, 0, 255),                    8'd255, 8'd255, 8'd255};
        vecs[5]  = '{px1(2, 2, 50),                     8'd100, 8'd255, 8'd0};
        vecs[6]  = '{px1(1, 2, 64),                     8'd128, 8'd255, 8'd0};
        vecs[7]  = '{rowfill(0, 200),                   8'd255, 8'd255, 8'd255};
        vecs[8]  = '{px1(2, 1, 100),                    8'd200, 8'd255, 8'd255};
        vecs[9]  = '{px1(1, 0, 128),                    8'd255, 8'd255, 8'd255};
        vecs[10] = '{px1(0, 1, 127),                    8'd254, 8'd255, 8'd255};

        // Reset state, with the sink not ready: empty output must still accept
        dma_ready_in = 1'b0;
        step();
        step();
        chk("rst_valid", conv_valid, 0);
        chk("rst_data", conv_data, 0);
        chk("rst_last", conv_last, 0);
        chk("rst_ready", ready, 1);
        chk("rst_t100_ready", r100, 1);
        chk("rst_t100_last", l100, 0);
        chk("rst_t200_ready", r200, 1);
        chk("rst_t200_last", l200, 0);
        rst = 1'b0;
        dma_ready_in = 1'b1;
        step();

        foreach (vecs[i]) begin
            pixel_data_valid_in = 1'b1;
            pixel_data_in = vecs[i].w;
            step();
            pixel_data_valid_in = 1'b0;
            step();
            chk("vec_early_valid", conv_valid, 0);
            step();
            chk("vec_valid", conv_valid, 1);
            chk("vec_t100_valid", v100, 1);
            chk("vec_t200_valid", v200, 1);
            chk("vec_out_thr0", conv_data, vecs[i].e0);
            chk("vec_out_thr100", d100, vecs[i].e100);
            chk("vec_out_thr200", d200, vecs[i].e200);
        end

        // Ten windows with a five-cycle sink stall mid-stream
        do_reset();
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            dma_ready_in = !(cyc >= 6 && cyc < 11);
            pixel_data_valid_in = (sent < 10);
            pixel_data_in = (sent < 10) ? px1(2, 2, 5 + 10 * sent) : '0;
            #1;
            acc = pixel_data_valid_in && ready;
            if (!dma_ready_in && conv_valid) begin
                chk("stall_ready", ready, 0);
                if (prev_stall) chk("stall_hold", conv_data, prev_data);
            end
            if (conv_valid && dma_ready_in) begin
                chk("stream_data", conv_data, 10 + 20 * got);
                got++;
            end
            prev_stall = !dma_ready_in && conv_valid;
            prev_data = conv_data;
            @(posedge Clk);
            #1;
            if (acc) sent++;
        end
        pixel_data_valid_in = 1'b0;
        chk("stream_count", got, 10);
        chk("stream_sent", sent, 10);
        step();
        chk("stream_no_dup", conv_valid, 0);

        // Two frames plus one pixel: last on outputs 8 and 16, then wrap
        do_reset();
        run_stream(17, "frame");

        // Reset with a stalled, full pipeline
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pixel_data_valid_in = 1'b1;
            pixel_data_in = px1(2, 2, 40 + k);
            step();
        end
        pixel_data_valid_in = 1'b0;
        dma_ready_in = 1'b0;
        #1;
        chk("inflight_valid", conv_valid, 1);
        chk("inflight_ready", ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", conv_valid, 0);
        chk("midrst_data", conv_data, 0);
        chk("midrst_last", conv_last, 0);
        chk("midrst_ready", ready, 1);
        step();
        rst = 1'b0;
        step();
        run_stream(8, "postrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
